// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared types, widths and helpers for the FP normalization sequencer
package fp_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MANT_W_DEF = 25;
    localparam int EXP_W_DEF  = 8;
    localparam int STEP_DEF   = 4;
    localparam int SIG_W      = 24;
    localparam int LZ_W       = 5;
    localparam int EXP_MAX    = (1 << EXP_W_DEF) - 1;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/fp_norm_sequencer_lzc24.sv
// rtl/fp_norm_sequencer_lzc24.sv - combinational 24-bit leading-zero counter (24 for all-zeros)
module lzc24
    import fp_norm_pkg::*;
(
    input  logic [SIG_W-1:0] value,
    output logic [LZ_W-1:0]  count
);

    // Scan upward so the highest set bit is the last one to assign.
    always_comb begin
        count = LZ_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (value[i]) begin
                count = LZ_W'(SIG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_sequencer.sv
// rtl/fp_norm_sequencer.sv - iterative post-add normalizer with valid/ready on both sides
module fp_norm_sequencer
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int STEP   = STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_significand,
    input  logic [EXP_W-1:0]  in_exponent,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-2:0] out_significand,
    output logic [EXP_W-1:0]  out_exponent,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_overflow,
    output logic              out_underflow
);

    localparam logic [EXP_W:0] ALL_ONES = (EXP_W+1)'((1 << EXP_W) - 1);

    state_t            state, state_n;
    logic [MANT_W-1:0] sig, sig_n;
    logic [EXP_W:0]    exp, exp_n, amt;
    logic              sign, sign_n;
    logic              zero, zero_n, ovf, ovf_n, unf, unf_n;
    logic [LZ_W-1:0]   lz;

    lzc24 u_lzc (
        .value (sig[MANT_W-2:0]),
        .count (lz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sig   <= '0;
            exp   <= '0;
            sign  <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_n;
            sig   <= sig_n;
            exp   <= exp_n;
            sign  <= sign_n;
            zero  <= zero_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end

    always_comb begin
        state_n = state;
        sig_n   = sig;
        exp_n   = exp;
        sign_n  = sign;
        zero_n  = zero;
        ovf_n   = ovf;
        unf_n   = unf;
        // exp >= 2 whenever the shift rule is reached, so exp-1 never goes negative there.
        amt     = (EXP_W+1)'(min3(int'(lz), STEP, int'(exp) - 1));
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sig_n   = in_significand;
                    exp_n   = {1'b0, in_exponent};
                    sign_n  = in_sign;
                    zero_n  = 1'b0;
                    ovf_n   = 1'b0;
                    unf_n   = 1'b0;
                    state_n = NORM;
                end
            end
            NORM: begin
                if (sig == '0) begin
                    exp_n   = '0;
                    zero_n  = 1'b1;
                    state_n = DONE;
                end else if (sig[MANT_W-1]) begin
                    sig_n = sig >> 1;
                    exp_n = exp + 1'b1;
                    // Saturate rather than let an all-ones input carry past the top.
                    if (exp_n >= ALL_ONES) begin
                        exp_n = ALL_ONES;
                        sig_n = '0;
                        ovf_n = 1'b1;
                    end
                    state_n = DONE;
                end else if (sig[MANT_W-2]) begin
                    state_n = DONE;
                end else if (exp <= 1) begin
                    exp_n   = '0;
                    unf_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    sig_n = sig << amt;
                    exp_n = exp - amt;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready        = (state == IDLE);
    assign out_valid       = (state == DONE);
    assign out_significand = sig[MANT_W-2:0];
    assign out_exponent    = exp[EXP_W-1:0];
    assign out_sign        = sign;
    assign out_zero        = zero;
    assign out_overflow    = ovf;
    assign out_underflow   = unf;

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// tb/tb_fp_norm_sequencer.sv - directed scoreboard bench for fp_norm_sequencer
module tb_fp_norm_sequencer;
    import fp_norm_pkg::*;

    typedef struct {
        logic [23:0] sig;
        logic [7:0]  exp;
        logic        sign;
        logic        zero;
        logic        ovf;
        logic        unf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_significand;
    logic [7:0]  in_exponent;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_significand;
    logic [7:0]  out_exponent;
    logic        out_sign;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    fp_norm_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_significand  (in_significand),
        .in_exponent     (in_exponent),
        .in_sign         (in_sign),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_significand (out_significand),
        .out_exponent    (out_exponent),
        .out_sign        (out_sign),
        .out_zero        (out_zero),
        .out_overflow    (out_overflow),
        .out_underflow   (out_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand, wait for its result, compare against the scoreboard head,
    // optionally hold backpressure for `hold` cycles, then complete the handshake.
    task automatic do_op(input logic [24:0] s, input logic [7:0] e, input logic sg,
                         input logic [23:0] xs, input logic [7:0] xe,
                         input logic xz, input logic xo, input logic xu,
                         input int xlat, input int hold);
        exp_t x;
        exp_t h;
        int   cyc;
        x.sig = xs; x.exp = xe; x.sign = sg; x.zero = xz; x.ovf = xo; x.unf = xu; x.lat = xlat;
        sb.push_back(x);
        out_ready = (hold == 0);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_significand = s;
        in_exponent    = e;
        in_sign        = sg;
        in_valid       = 1'b1;
        cyc = 0;
        do begin
            tick();
            in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 50);
        h = sb.pop_front();
        if (!out_valid) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("latency",  32'(cyc),             32'(h.lat));
            check("out_sig",  32'(out_significand), 32'(h.sig));
            check("out_exp",  32'(out_exponent),    32'(h.exp));
            check("out_sign", 32'(out_sign),        32'(h.sign));
            check("out_zero", 32'(out_zero),        32'(h.zero));
            check("out_ovf",  32'(out_overflow),    32'(h.ovf));
            check("out_unf",  32'(out_underflow),   32'(h.unf));
            for (int i = 0; i < hold; i++) begin
                tick();
                check("bp_valid", 32'(out_valid),       32'd1);
                check("bp_ready", 32'(in_ready),        32'd0);
                check("bp_sig",   32'(out_significand), 32'(h.sig));
                check("bp_exp",   32'(out_exponent),    32'(h.exp));
                check("bp_zero",  32'(out_zero),        32'(h.zero));
            end
            out_ready = 1'b1;
            tick();
            check("post_ready", 32'(in_ready),  32'd1);
            check("post_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        in_valid = 1'b0;
        in_significand = '0;
        in_exponent = '0;
        in_sign = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready),        32'd1);
        check("rst_valid",    32'(out_valid),       32'd0);
        check("rst_sig",      32'(out_significand), 32'd0);
        check("rst_exp",      32'(out_exponent),    32'd0);
        check("rst_sign",     32'(out_sign),        32'd0);
        check("rst_flags",    32'({out_zero, out_overflow, out_underflow}), 32'd0);

        do_op(25'h0C00000, 8'h80, 1'b0, 24'hC00000, 8'h80, 0, 0, 0, 2, 0);
        do_op(25'h1800001, 8'h80, 1'b1, 24'hC00000, 8'h81, 0, 0, 0, 2, 0);
        do_op(25'h0000001, 8'h80, 1'b0, 24'h800000, 8'h69, 0, 0, 0, 8, 0);
        do_op(25'h0000100, 8'h05, 1'b1, 24'h001000, 8'h00, 0, 0, 1, 3, 0);
        do_op(25'h1000000, 8'hFE, 1'b0, 24'h000000, EXP_MAX[7:0], 0, 1, 0, 2, 0);
        do_op(25'h0400000, 8'h10, 1'b1, 24'h800000, 8'h0F, 0, 0, 0, 3, 0);
        do_op(25'h0800000, 8'h01, 1'b0, 24'h800000, 8'h01, 0, 0, 0, 2, 0);
        do_op(25'h0000010, 8'h03, 1'b0, 24'h000040, 8'h00, 0, 0, 1, 3, 0);
        do_op(25'h0000000, 8'h55, 1'b1, 24'h000000, 8'h00, 1, 0, 0, 2, 3);

        // Abandon a deep-shift operation mid-normalization.
        in_significand = 25'h0000001;
        in_exponent    = 8'h80;
        in_valid       = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ready", 32'(in_ready),  32'd1);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_output", 32'(seen), 32'd0);

        do_op(25'h0C00000, 8'h80, 1'b1, 24'hC00000, 8'h80, 0, 0, 0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_norm_sequencer.md
Name: fp_norm_sequencer

Overview:
Multi-cycle normalization controller for the FP add/sub pipeline. Accepts the raw 25-bit adder significand (bit 24 = carry-out) with its exponent and sign. It renormalizes iteratively, at most STEP bits of left shift per cycle, using a shared leading-zero counter, and returns a normalized 24-bit significand. Saturation and underflow are handled at the exponent limits. Valid/ready handshakes are used on both sides; it sits between the adder stage and the rounding stage.

Parameters:
MANT_W, 25, input significand width incl. carry bit (output width MANT_W-1)
EXP_W, 8, exponent width
STEP, 4, maximum left-shift distance per cycle (1..MANT_W-2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input operand valid
in_ready  out  1  block can accept an operand
in_significand  in  MANT_W  raw sum; bit 24 carry, bit 23 hidden-one position
in_exponent  in  EXP_W  biased exponent of the larger operand
in_sign  in  1  result sign
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_significand  out  MANT_W-1  normalized significand, bit 23 = hidden one unless zero/underflow
out_exponent  out  EXP_W  adjusted biased exponent
out_sign  out  1  passed through from accept
out_zero  out  1  significand was zero
out_overflow  out  1  exponent reached 2^EXP_W-1
out_underflow  out  1  normalization stopped at exponent 0 (denormal)

Behaviour:
- Reset: state IDLE; in_ready=1. out_valid, out_zero, out_overflow and out_underflow are 0; out_significand, out_exponent and out_sign are 0. Reset in any state abandons the operation; no output is produced.
- FSM: IDLE -> NORM -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid=1, latch the significand, exponent and sign into work registers, clear the flags, and move to NORM.
- NORM: in_ready=0, out_valid=0. Exactly one rule per cycle, in priority order:
  1. sig==0: exponent:=0, out_zero=1, go to DONE.
  2. sig[24]=1: sig:=sig>>1 (LSB dropped, truncation; rounding is downstream); exp:=exp+1. If the new exp equals all-ones, force sig:=0 and set out_overflow. Go to DONE.
  3. sig[23]=1: go to DONE.
  4. exp<=1: exp:=0, out_underflow=1, sig unchanged, go to DONE.
  5. Otherwise: lz = leading zeros of sig[23:0]; amt = min(lz, STEP, exp-1); sig:=sig<<amt; exp:=exp-amt; stay in NORM.
- NORM cycle count is 1 + ceil(lz/STEP), unless capped by the exponent. out_valid asserts on the first cycle after the final NORM cycle.
- DONE: out_valid=1. All outputs are registered and held stable while out_ready=0. On out_valid&&out_ready, go to IDLE. in_ready is 0 in DONE; there is no accept-while-draining, so the next accept is at the earliest one cycle after the handshake.
- Exponent arithmetic uses EXP_W+1 bits internally, so no wrap-around can occur. Input exponent all-ones is passed through unchanged unless rule 2 fires.
- in_valid in NORM or DONE is ignored (not latched).

Decomposition:
- Package fp_norm_pkg holds:
  - state enum {IDLE, NORM, DONE}
  - EXP_MAX = 2^EXP_W-1
  - width localparams
  - min3 helper function
- Sub-module lzc24: combinational leading-zero counter, 24-bit in, 5-bit count out, count=24 for all-zeros. It is instantiated once and shared across iterations.

Test Plan:
- Already normalized: sig=0x0C00000, exp=0x80 -> out_sig=0xC00000, exp=0x80, no flags; out_valid 2 cycles after accept.
- Carry: sig=0x1800001, exp=0x80 -> out_sig=0xC00000 (LSB truncated), exp=0x81; 1 NORM cycle.
- Deep shift: sig=0x0000001, exp=0x80 -> out_sig=0x800000, exp=0x69; 7 NORM cycles; out_valid 8 cycles after accept.
- Underflow: sig=0x0000100, exp=0x05 -> one shift of 4, then stop; out_sig=0x001000, exp=0x00, out_underflow=1.
- Overflow: sig=0x1000000, exp=0xFE -> exp=0xFF, out_sig=0, out_overflow=1.
- Zero plus backpressure plus reset:
  - sig=0, exp=0x55 -> out_zero=1, exp=0x00.
  - Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0.
  - Assert out_ready: in_ready=1 the next cycle.
  - Assert reset during NORM of a deep-shift op: out_valid never rises, in_ready=1 the cycle after reset.
